// File: rtl/block_data_memory_if.sv
// Block memory request/response bundle.
//   read, write     : request strobes, held by the requester until busywait drops
//   address         : block address (byte address bits [31:4])
//   writedata       : block to write, word 0 in [31:0]
//   readdata        : block returned by the last completed read
//   busywait        : request pending
//   protocol_error  : one-cycle pulse after read and write were both seen in IDLE
interface block_data_memory_if;
  logic         read;
  logic         write;
  logic [27:0]  address;
  logic [127:0] writedata;
  logic [127:0] readdata;
  logic         busywait;
  logic         protocol_error;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait, protocol_error
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait, protocol_error
  );
endinterface

// File: rtl/block_data_memory.sv
// Multi-cycle block data memory: 2**DEPTH_LOG2 blocks of 128 bits, each access
// takes LATENCY cycles in ACCESS followed by a single DONE cycle.
//   clock : sole clock, rising edge
//   reset : asynchronous, active high; clears FSM, readdata and all blocks
//   bus   : block_data_memory_if.slave (read/write/address/writedata in,
//           readdata/busywait/protocol_error out)
module block_data_memory #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 5
) (
  input logic                  clock,
  input logic                  reset,
  block_data_memory_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              cnt;
  logic                    op_wr;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [127:0]            wdata;
  logic [127:0]            rdata;
  logic                    perr;
  logic                    busy;
  logic [127:0]            mem [DEPTH];

  logic req_one, req_both;
  assign req_one  = bus.read ^ bus.write;
  assign req_both = bus.read & bus.write;

  // Upper address bits alias onto the same blocks.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[27:DEPTH_LOG2];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_one) state_nxt = ACCESS;
      ACCESS:  if (cnt == 8'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy is combinational in IDLE so the requester sees it in the
  // same cycle it raises the request; both-high is not a request.
  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:    busy = req_one;
      ACCESS:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign bus.busywait       = busy;
  assign bus.readdata       = rdata;
  assign bus.protocol_error = perr;

  // Datapath: request is captured on entry so ACCESS ignores input changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      op_wr <= 1'b0;
      idx   <= '0;
      wdata <= '0;
      rdata <= '0;
      perr  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      perr <= (state == IDLE) && req_both;
      case (state)
        IDLE: begin
          if (req_one) begin
            cnt   <= 8'(LATENCY - 1);
            op_wr <= bus.write;
            idx   <= bus.address[DEPTH_LOG2-1:0];
            wdata <= bus.writedata;
          end
        end
        ACCESS: begin
          if (cnt == 8'd0) begin
            if (op_wr) mem[idx] <= wdata;
            else       rdata    <= mem[idx];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: a LATENCY=5 instance carries the
// main sequence, a LATENCY=1 instance checks the short-latency case.
module tb_block_data_memory;

  logic clock, reset;

  block_data_memory_if bus0 ();
  block_data_memory_if bus1 ();

  block_data_memory #(.DEPTH_LOG2(8), .LATENCY(5)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  block_data_memory #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] model [256];
  logic [127:0] sb [$];
  logic [127:0] last_rd;
  bit           pend_wr;
  logic [7:0]   pend_idx;
  logic [127:0] pend_d;

  localparam logic [127:0] D1 = 128'h44443333222211110000DDDDCCCCBBBB;
  localparam logic [127:0] D2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;
  localparam logic [127:0] D4 = 128'h11112222333344445555666677778888;
  localparam logic [127:0] D5 = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit wr, input logic [27:0] a, input logic [127:0] d);
    bus0.write     = wr;
    bus0.read      = !wr;
    bus0.address   = a;
    bus0.writedata = d;
    pend_wr  = wr;
    pend_idx = a[7:0];
    pend_d   = d;
    if (!wr) sb.push_back(model[a[7:0]]);
  endtask

  task automatic idle_req();
    bus0.read  = 1'b0;
    bus0.write = 1'b0;
  endtask

  // Called in the cycle the request was raised; returns in the DONE cycle.
  task automatic wait_done(input string tag, input int exp_busy);
    int n = 0;
    logic [127:0] e;
    #1;
    while (bus0.busywait === 1'b1 && n < 300) begin
      n++;
      @(negedge clock); #1;
    end
    chk({tag, " busy cycles"}, 128'(n), 128'(exp_busy));
    chk({tag, " perr"}, 128'(bus0.protocol_error), 128'(0));
    if (pend_wr) begin
      model[pend_idx] = pend_d;
      chk({tag, " rdata hold"}, bus0.readdata, last_rd);
    end else begin
      e = (sb.size() > 0) ? sb.pop_front() : 128'hx;
      chk({tag, " rdata"}, bus0.readdata, e);
      last_rd = e;
    end
  endtask

  initial begin
    foreach (model[i]) model[i] = '0;
    last_rd = '0;
    reset = 1'b1;
    bus0.read = 0; bus0.write = 0; bus0.address = '0; bus0.writedata = '0;
    bus1.read = 0; bus1.write = 0; bus1.address = '0; bus1.writedata = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst rdata",  bus0.readdata, '0);
    chk("rst busy",   128'(bus0.busywait), 128'(0));
    chk("rst perr",   128'(bus0.protocol_error), 128'(0));
    chk("rst rdata1", bus1.readdata, '0);
    @(negedge clock); reset = 1'b0;

    // basic write, read back, aliasing, untouched block
    @(negedge clock); drive_req(1, 28'h0000012, D1); wait_done("wr12", 6); idle_req();
    @(negedge clock); drive_req(0, 28'h0000012, '0); wait_done("rd12", 6); idle_req();
    @(negedge clock); drive_req(0, 28'h0000112, '0); wait_done("rd112", 6); idle_req();
    @(negedge clock); drive_req(0, 28'h0000013, '0); wait_done("rd13", 6); idle_req();

    // write, then switch to read in the DONE cycle: no IDLE gap
    @(negedge clock); drive_req(1, 28'h0000021, D2); wait_done("wr21", 6); idle_req();
    @(negedge clock); drive_req(1, 28'h0000020, D3); wait_done("wr20", 6);
    drive_req(0, 28'h0000021, '0);
    @(negedge clock); wait_done("b2b rd21", 6); idle_req();
    @(negedge clock); drive_req(0, 28'h0000020, '0); wait_done("rd20", 6); idle_req();

    // read and write together: error pulse, no access
    @(negedge clock);
    bus0.read = 1; bus0.write = 1; bus0.address = 28'h0000012; bus0.writedata = D5;
    #1 chk("both busy", 128'(bus0.busywait), 128'(0));
    @(negedge clock); idle_req();
    #1 chk("both perr", 128'(bus0.protocol_error), 128'(1));
    @(negedge clock);
    #1 chk("perr pulse end", 128'(bus0.protocol_error), 128'(0));
    @(negedge clock); drive_req(0, 28'h0000012, '0); wait_done("rd12 after err", 6); idle_req();

    // reset in third ACCESS cycle of a write
    @(negedge clock); drive_req(1, 28'h0000030, D4);
    #1 chk("abort busy0", 128'(bus0.busywait), 128'(1));
    repeat (3) @(negedge clock);
    reset = 1'b1; idle_req();
    #1;
    chk("abort rdata", bus0.readdata, '0);
    chk("abort busy",  128'(bus0.busywait), 128'(0));
    @(negedge clock); reset = 1'b0;
    foreach (model[i]) model[i] = '0;
    sb.delete();
    last_rd = '0;
    @(negedge clock); drive_req(0, 28'h0000030, '0); wait_done("rd30 post rst", 6); idle_req();
    @(negedge clock); drive_req(0, 28'h0000012, '0); wait_done("rd12 post rst", 6); idle_req();

    // LATENCY 1 instance
    begin
      int n;
      @(negedge clock);
      bus1.write = 1; bus1.address = 28'h0000005; bus1.writedata = D5;
      n = 0; #1;
      while (bus1.busywait === 1'b1 && n < 300) begin n++; @(negedge clock); #1; end
      chk("l1 wr busy", 128'(n), 128'(2));
      chk("l1 wr rdata hold", bus1.readdata, '0);
      bus1.write = 0;
      @(negedge clock);
      bus1.read = 1;
      n = 0; #1;
      while (bus1.busywait === 1'b1 && n < 300) begin n++; @(negedge clock); #1; end
      chk("l1 rd busy", 128'(n), 128'(2));
      chk("l1 rd rdata", bus1.readdata, D5);
      bus1.read = 0;
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
